// File: rtl/pairhmm_pkg.sv
// Shared types and defaults for the Pair-HMM wavefront scheduler and PE array.
package pairhmm_pkg;

  localparam int MAX_LEN_DEFAULT = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    FINAL = 3'd3,
    ERR   = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic [31:0] m;
    logic [31:0] x;
    logic [31:0] y;
  } pe_calcs_t;

  typedef struct packed {
    logic [15:0] match;
    logic [15:0] mismatch;
  } priors_t;

endpackage

// File: rtl/pairhmm_pe_window.sv
// Combinational enable/column window for one PE: enabled while its column
// t-IDX lies inside the reference and its row exists in the current strip.
module pairhmm_pe_window
  import pairhmm_pkg::*;
#(
  parameter int LW  = 9,
  parameter int IDX = 0
) (
  input  logic [LW:0]   t,
  input  logic [LW:0]   rows,
  input  logic [LW-1:0] x_len,
  output logic          en,
  output logic [LW-1:0] col
);

  localparam logic [LW:0] IDX_W = (LW+1)'(IDX);

  logic [LW:0] diff;

  always_comb begin
    diff = t - IDX_W;
    en   = (IDX_W < rows) && (t >= IDX_W) && (diff < {1'b0, x_len});
    col  = en ? diff[LW-1:0] : '0;
  end

endmodule

// File: rtl/pairhmm_wavefront_sched.sv
// Strip-mined wavefront scheduler for the Pair-HMM systolic array: walks the
// DP matrix in strips of NUM_PROCS rows and drives PE enables and checkpoints.
module pairhmm_wavefront_sched
  import pairhmm_pkg::*;
#(
  parameter int NUM_PROCS = 4,
  parameter int MAX_LEN   = MAX_LEN_DEFAULT,
  parameter int LW        = $clog2(MAX_LEN+1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LW-1:0]           x_len,
  input  logic [LW-1:0]           y_len,
  input  logic [NUM_PROCS-1:0]    pe_done,
  output logic                    busy,
  output logic                    job_done,
  output logic                    len_err,
  output logic [NUM_PROCS-1:0]    enables,
  output logic [NUM_PROCS*LW-1:0] pe_col,
  output logic [LW-1:0]           row_base,
  output logic                    advance,
  output logic                    ckpt_wr_en,
  output logic [LW-1:0]           ckpt_wr_addr,
  output logic                    ckpt_rd_en,
  output logic [LW-1:0]           ckpt_rd_addr,
  output logic                    final_valid,
  output logic [$clog2(NUM_PROCS):0] final_sel
);

  localparam int          FW      = $clog2(NUM_PROCS) + 1;
  localparam logic [LW:0] P_W     = (LW+1)'(NUM_PROCS);
  localparam logic [LW:0] ONE_W   = (LW+1)'(1);
  localparam logic [LW+1:0] TWO_W = (LW+2)'(2);
  localparam logic [LW-1:0] MAX_W = LW'(MAX_LEN);

  sched_state_t state, state_nxt;

  logic [LW:0]   t, t_nxt;
  logic [LW:0]   rows, rows_nxt;
  logic [LW-1:0] strip, strip_nxt;
  logic [LW-1:0] rb_nxt;
  logic [LW-1:0] x_len_q, y_len_q;

  logic [LW:0]   rb_plus_p;
  logic [LW:0]   rows_m1;
  logic [LW:0]   wr_diff;
  logic [LW+1:0] last_step;
  logic          last_strip;
  logic          at_last_step;
  logic          len_bad;
  logic          last_row_en;

  logic [NUM_PROCS-1:0]    win_en;
  logic [NUM_PROCS*LW-1:0] win_col;

  function automatic logic [LW:0] strip_rows(input logic [LW:0] remaining);
    return (remaining < P_W) ? remaining : P_W;
  endfunction

  assign rb_plus_p    = {1'b0, row_base} + P_W;
  assign last_strip   = (rb_plus_p >= {1'b0, y_len_q});
  assign last_step    = {2'b0, x_len_q} + {1'b0, rows} - TWO_W;
  assign at_last_step = ({1'b0, t} == last_step);
  assign rows_m1      = rows - ONE_W;
  assign wr_diff      = t - rows_m1;
  assign len_bad      = (x_len == '0) || (x_len > MAX_W) ||
                        (y_len == '0) || (y_len > MAX_W);
  assign advance      = (state == RUN) && (&(pe_done | ~enables));

  // Enable of the bottom row of the strip, whose output feeds the next strip.
  always_comb begin
    last_row_en = 1'b0;
    for (int i = 0; i < NUM_PROCS; i++) begin
      if ((LW+1)'(i) == rows_m1) last_row_en = enables[i];
    end
  end

  assign ckpt_wr_en   = advance && last_row_en && !last_strip;
  assign ckpt_wr_addr = (t >= rows_m1) ? wr_diff[LW-1:0] : '0;
  assign ckpt_rd_en   = enables[0] && (strip != '0);
  assign ckpt_rd_addr = pe_col[LW-1:0];

  assign busy        = (state == LOAD) || (state == RUN) || (state == FINAL);
  assign job_done    = (state == FINAL) || (state == ERR);
  assign len_err     = (state == ERR);
  assign final_valid = (state == FINAL);
  assign final_sel   = (state == FINAL) ? FW'(rows_m1) : '0;

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    rows_nxt  = rows;
    strip_nxt = strip;
    rb_nxt    = row_base;
    case (state)
      IDLE: begin
        if (start) state_nxt = len_bad ? ERR : LOAD;
      end
      ERR: state_nxt = IDLE;
      LOAD: begin
        state_nxt = RUN;
        t_nxt     = '0;
        strip_nxt = '0;
        rb_nxt    = '0;
        rows_nxt  = strip_rows({1'b0, y_len_q});
      end
      RUN: begin
        if (advance) begin
          if (!at_last_step) begin
            t_nxt = t + ONE_W;
          end else if (last_strip) begin
            state_nxt = FINAL;
          end else begin
            t_nxt     = '0;
            strip_nxt = strip + LW'(1);
            rb_nxt    = rb_plus_p[LW-1:0];
            rows_nxt  = strip_rows({1'b0, y_len_q} - rb_plus_p);
          end
        end
      end
      FINAL: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Windows are evaluated on the next step so enables/pe_col are registered.
  for (genvar i = 0; i < NUM_PROCS; i++) begin : g_win
    pairhmm_pe_window #(
      .LW (LW),
      .IDX(i)
    ) u_win (
      .t    (t_nxt),
      .rows (rows_nxt),
      .x_len(x_len_q),
      .en   (win_en[i]),
      .col  (win_col[i*LW +: LW])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      t        <= '0;
      rows     <= '0;
      strip    <= '0;
      row_base <= '0;
      x_len_q  <= '0;
      y_len_q  <= '0;
      enables  <= '0;
      pe_col   <= '0;
    end else begin
      state    <= state_nxt;
      t        <= t_nxt;
      rows     <= rows_nxt;
      strip    <= strip_nxt;
      row_base <= rb_nxt;
      if (state == IDLE && start) begin
        x_len_q <= x_len;
        y_len_q <= y_len;
      end
      enables <= (state_nxt == RUN) ? win_en  : '0;
      pe_col  <= (state_nxt == RUN) ? win_col : '0;
    end
  end

endmodule
